framebuffer_axis_streamer: RTL
==============================

Name: framebuffer_axis_streamer

Overview:
- Upstream feeder for the SPI display controller.
- On a start request it scans a finished RGBA4444 framebuffer out of on-chip RAM through the RAM's synchronous read port.
- Pixels leave as a 16-bit AXI Stream with tlast on the final pixel, directly driving the display controller's s_axis_* slave.
- Absorbs downstream backpressure without losing or duplicating pixels, despite the 1-cycle RAM read latency.

Parameters:
- X_RES, 128, pixels per line.
- Y_RES, 128, lines per frame.
- FB_ADDR_WIDTH, 14, framebuffer word-address width; must satisfy 2^FB_ADDR_WIDTH >= X_RES*Y_RES.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to stream one frame; ignored while busy.
- busy  out  1  high from the cycle after an accepted start until the cycle after the tlast beat is accepted.
- frameDone  out  1  one-cycle pulse in the cycle after the tlast beat is accepted.
- memReadEn  out  1  RAM read strobe.
- memReadAddr  out  FB_ADDR_WIDTH  RAM word address.
- memReadData  in  16  RAM data, valid exactly 1 cycle after memReadEn.
- m_axis_tvalid  out  1  AXIS valid.
- m_axis_tready  in  1  AXIS ready.
- m_axis_tlast  out  1  high on pixel X_RES*Y_RES-1 only.
- m_axis_tdata  out  16  RGBA4444 pixel {R[15:12],G[11:8],B[7:4],A[3:0]}, passed unmodified.

Behaviour:
Reset values:
- busy, frameDone, memReadEn, m_axis_tvalid, m_axis_tlast all 0; memReadAddr 0.
- FIFO empty; counters 0; state IDLE.

State machine:
- IDLE: start=1 -> clear x/y/issue/emit counters, load rowBase=0, go STREAM; busy=1 next cycle.
- STREAM: issue one read per cycle while (fifoCount + inFlight) < 2 and issued < X_RES*Y_RES. Go DRAIN when last read issued.
- DRAIN: no reads; emit remaining FIFO entries. On acceptance of the tlast beat -> IDLE, pulse frameDone, drop busy.

Addressing:
- memReadAddr = rowBase + x, with no multiplier.
- x increments to X_RES-1, then wraps to 0 and rowBase += X_RES.

Data path:
- Read data is written into a 2-entry FIFO one cycle after memReadEn.
- FIFO head drives m_axis_tdata/tvalid.
- Beat transfers when tvalid && tready; tdata/tlast are held stable while tvalid && !tready.
- Simultaneous FIFO push and pop in the same cycle is legal and keeps the count unchanged.
- The credit rule (count + inFlight < 2) guarantees no overflow; a push into a full FIFO is a design error, asserted in simulation.

Throughput and latency:
- With tready held high: 1 pixel/cycle sustained.
- First tvalid appears 3 cycles after the start cycle (start -> STREAM, read issue, data into FIFO).

tlast:
- Driven by emit counter == X_RES*Y_RES-1, travelling with the FIFO entry as a stored bit.

Boundary cases:
- start while busy: ignored, no restart.
- start in the same cycle as frameDone: ignored; accepted only from IDLE with busy=0.
- tready low for arbitrarily long: reads stall after 2 outstanding.
- reset mid-frame: in-flight read data discarded; outputs return to reset values next cycle.
- Counter widths sized by $clog2(X_RES*Y_RES)+1 to avoid wrap at the final count.

Optional Feature:
Macro FB_STREAMER_VFLIP_EN.
- Defined: lines scanned bottom-to-top; rowBase starts at (Y_RES-1)*X_RES and decrements by X_RES per line; x order and tlast rule unchanged.
- Undefined: top-to-bottom as above; no flip logic synthesised.

Decomposition:
- Shared package/include: pixel field positions (COLOR_R_POS=12, COLOR_G_POS=8, COLOR_B_POS=4, COLOR_A_POS=0, COLOR_SUB_PIXEL_WIDTH=4) and state encodings IDLE/STREAM/DRAIN.
- One sub-module: pixel_skid_fifo, a 2-entry 17-bit (data+last) FIFO with push/pop/count, reused for other AXIS stages.

Test Plan:
- X_RES=4,Y_RES=2, RAM[i]=16'h1000+i, tready=1, start -> 8 beats, 16'h1000..16'h1007 in order; tlast only on 16'h1007; frameDone 1 cycle after; first tvalid 3 cycles after start.
- Same frame, tready toggled 1/0 every cycle -> identical 8-beat sequence, no drop or duplicate; tdata stable during stalls; memReadEn never exceeds 2 outstanding.
- tready=0 for 20 cycles after start -> exactly 2 reads issued, tvalid=1 held with 16'h1000; on release the full sequence completes.
- start pulsed again mid-frame and in the frameDone cycle -> ignored; busy stays continuous; one frame only.
- reset asserted at beat 3 -> next cycle tvalid=0, busy=0, memReadEn=0; new start streams from 16'h1000 again.
- FB_STREAMER_VFLIP_EN defined, 4x2 frame -> beats 16'h1004..16'h1007 then 16'h1000..16'h1003; tlast on 16'h1003.

Source files
------------

// File: rtl/framebuffer_axis_streamer_pkg.sv
// Shared definitions for the framebuffer streamer: RGBA4444 field layout and FSM state encoding.
// Consumers: framebuffer_axis_streamer and its pixel skid FIFO.
package framebuffer_axis_streamer_pkg;

  localparam int unsigned COLOR_R_POS           = 12;
  localparam int unsigned COLOR_G_POS           = 8;
  localparam int unsigned COLOR_B_POS           = 4;
  localparam int unsigned COLOR_A_POS           = 0;
  localparam int unsigned COLOR_SUB_PIXEL_WIDTH = 4;
  localparam int unsigned PIXEL_WIDTH           = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } streamState_e;

  function automatic logic [PIXEL_WIDTH-1:0] packPixel(
    input logic [COLOR_SUB_PIXEL_WIDTH-1:0] r,
    input logic [COLOR_SUB_PIXEL_WIDTH-1:0] g,
    input logic [COLOR_SUB_PIXEL_WIDTH-1:0] b,
    input logic [COLOR_SUB_PIXEL_WIDTH-1:0] a
  );
    logic [PIXEL_WIDTH-1:0] p;
    p = '0;
    p[COLOR_R_POS +: COLOR_SUB_PIXEL_WIDTH] = r;
    p[COLOR_G_POS +: COLOR_SUB_PIXEL_WIDTH] = g;
    p[COLOR_B_POS +: COLOR_SUB_PIXEL_WIDTH] = b;
    p[COLOR_A_POS +: COLOR_SUB_PIXEL_WIDTH] = a;
    return p;
  endfunction

endpackage

// File: rtl/framebuffer_axis_streamer_pixel_skid_fifo.sv
// pixel_skid_fifo: 2-entry FIFO carrying {last, pixel}; head is presented combinationally.
// Simultaneous push and pop are allowed, including on a full FIFO.
module framebuffer_axis_streamer_pixel_skid_fifo
  import framebuffer_axis_streamer_pkg::*;
#(
  parameter int unsigned WIDTH = PIXEL_WIDTH + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic [WIDTH-1:0] popData,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [2];
  logic             wrPtr;
  logic             rdPtr;
  logic             doPop;

  assign doPop   = pop && (count != 2'd0);
  assign popData = mem[rdPtr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wrPtr] <= pushData;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr <= 1'b0;
      rdPtr <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) begin
        wrPtr <= ~wrPtr;
      end
      if (doPop) begin
        rdPtr <= ~rdPtr;
      end
      count <= count + {1'b0, push} - {1'b0, doPop};
    end
  end

  // Upstream credit accounting must make this impossible.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(push && (count == 2'd2) && !doPop));
    end
  end

endmodule

// File: rtl/framebuffer_axis_streamer.sv
// Scans an RGBA4444 framebuffer out of a synchronous-read RAM as a 16-bit AXI Stream frame.
// Define FB_STREAMER_VFLIP_EN to scan lines bottom-to-top.
module framebuffer_axis_streamer
  import framebuffer_axis_streamer_pkg::*;
#(
  parameter int unsigned X_RES         = 128,
  parameter int unsigned Y_RES         = 128,
  parameter int unsigned FB_ADDR_WIDTH = 14
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic                     busy,
  output logic                     frameDone,
  output logic                     memReadEn,
  output logic [FB_ADDR_WIDTH-1:0] memReadAddr,
  input  logic [15:0]              memReadData,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     m_axis_tlast,
  output logic [15:0]              m_axis_tdata
);

  localparam int unsigned NumPix = X_RES * Y_RES;
  localparam int unsigned CntW   = $clog2(NumPix) + 1;

  localparam logic [CntW-1:0]          LastPix   = CntW'(NumPix - 1);
  localparam logic [CntW-1:0]          NumPixCnt = CntW'(NumPix);
  localparam logic [FB_ADDR_WIDTH-1:0] XLast     = FB_ADDR_WIDTH'(X_RES - 1);
  localparam logic [FB_ADDR_WIDTH-1:0] XStep     = FB_ADDR_WIDTH'(X_RES);
`ifdef FB_STREAMER_VFLIP_EN
  localparam logic [FB_ADDR_WIDTH-1:0] RowBaseInit = FB_ADDR_WIDTH'((Y_RES - 1) * X_RES);
`else
  localparam logic [FB_ADDR_WIDTH-1:0] RowBaseInit = '0;
`endif

  streamState_e             state;
  logic [FB_ADDR_WIDTH-1:0] x;
  logic [FB_ADDR_WIDTH-1:0] rowBase;
  logic [CntW-1:0]          issueCount;
  logic [CntW-1:0]          emitCount;
  logic                     inFlight;
  logic [1:0]               fifoCount;
  logic [PIXEL_WIDTH:0]     fifoHead;
  logic [PIXEL_WIDTH:0]     fifoIn;
  logic                     pop;
  logic                     lastBeat;
  logic [2:0]               occupancy;

  assign m_axis_tvalid = (fifoCount != 2'd0);
  assign m_axis_tlast  = m_axis_tvalid && fifoHead[PIXEL_WIDTH];
  assign m_axis_tdata  = packPixel(fifoHead[COLOR_R_POS +: COLOR_SUB_PIXEL_WIDTH],
                                   fifoHead[COLOR_G_POS +: COLOR_SUB_PIXEL_WIDTH],
                                   fifoHead[COLOR_B_POS +: COLOR_SUB_PIXEL_WIDTH],
                                   fifoHead[COLOR_A_POS +: COLOR_SUB_PIXEL_WIDTH]);

  assign pop      = m_axis_tvalid && m_axis_tready;
  assign lastBeat = pop && fifoHead[PIXEL_WIDTH];

  // A pop this cycle frees a slot before the read issued now lands, keeping 1 pixel/cycle.
  assign occupancy = {1'b0, fifoCount} + {2'b00, inFlight};
  assign memReadEn = (state == STREAM) && (issueCount != NumPixCnt) &&
                     (occupancy < (3'd2 + {2'b00, pop}));
  assign memReadAddr = rowBase + x;

  assign fifoIn = {(emitCount == LastPix), memReadData};

  framebuffer_axis_streamer_pixel_skid_fifo #(
    .WIDTH (PIXEL_WIDTH + 1)
  ) u_pixel_skid_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (inFlight),
    .pushData (fifoIn),
    .pop      (pop),
    .popData  (fifoHead),
    .count    (fifoCount)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      frameDone  <= 1'b0;
      x          <= '0;
      rowBase    <= '0;
      issueCount <= '0;
      emitCount  <= '0;
      inFlight   <= 1'b0;
    end else begin
      frameDone <= 1'b0;
      inFlight  <= memReadEn;
      if (inFlight) begin
        emitCount <= emitCount + CntW'(1);
      end
      unique case (state)
        IDLE: begin
          // The frameDone cycle is still part of the finished frame.
          if (start && !frameDone) begin
            state      <= STREAM;
            busy       <= 1'b1;
            x          <= '0;
            rowBase    <= RowBaseInit;
            issueCount <= '0;
            emitCount  <= '0;
          end
        end
        STREAM: begin
          if (memReadEn) begin
            issueCount <= issueCount + CntW'(1);
            if (x == XLast) begin
              x <= '0;
`ifdef FB_STREAMER_VFLIP_EN
              rowBase <= rowBase - XStep;
`else
              rowBase <= rowBase + XStep;
`endif
            end else begin
              x <= x + FB_ADDR_WIDTH'(1);
            end
            if (issueCount == LastPix) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (lastBeat) begin
            state     <= IDLE;
            busy      <= 1'b0;
            frameDone <= 1'b1;
            x         <= '0;
            rowBase   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
